// File: rtl/irq_ctrl.sv
// Machine interrupt controller: mip capture, masking, fixed-priority pick, req/ack to trap unit.
// Latency: std level->mip 1 cycle, plat edge->mip SYNC_STAGES+1; eligible->trap_req_o 1 cycle; code frozen until ack/withdraw.
module irq_ctrl #(
  parameter int NUM_PLAT_IRQ = 10,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    msi_i,
  input  logic                    mti_i,
  input  logic                    mei_i,
  input  logic [NUM_PLAT_IRQ-1:0] plat_irq_i,
  input  logic [31:0]             mie_i,
  input  logic                    mstatus_mie_i,
  input  logic                    pend_clr_i,
  input  logic [4:0]              pend_clr_code_i,
  output logic [31:0]             mip_o,
  output logic                    trap_req_o,
  output logic [4:0]              trap_code_o,
  input  logic                    trap_ack_i
);

  typedef struct packed {
    logic [15-NUM_PLAT_IRQ:0] rsvd_hi;
    logic [NUM_PLAT_IRQ-1:0]  plat;
    logic [3:0]               rsvd_12;
    logic                     mei;
    logic [2:0]               rsvd_8;
    logic                     mti;
    logic [2:0]               rsvd_4;
    logic                     msi;
    logic [2:0]               rsvd_0;
  } interrupt_csr_t;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  logic                                   msi_q, mti_q, mei_q;
  logic [SYNC_STAGES-1:0][NUM_PLAT_IRQ-1:0] plat_sync;
  logic [NUM_PLAT_IRQ-1:0]                plat_hist;
  logic [NUM_PLAT_IRQ-1:0]                plat_rise;
  logic [NUM_PLAT_IRQ-1:0]                plat_pend;
  logic [NUM_PLAT_IRQ-1:0]                plat_clr;
  logic [NUM_PLAT_IRQ-1:0]                plat_pend_nxt;
  interrupt_csr_t                         mip;
  logic [31:0]                            eligible;
  logic                                   any_elig;
  logic [4:0]                             win_code;
  state_t                                 state_q, state_nxt;
  logic                                   req_nxt;
  logic [4:0]                             code_nxt;
  logic                                   ack_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msi_q     <= 1'b0;
      mti_q     <= 1'b0;
      mei_q     <= 1'b0;
      plat_sync <= '0;
      plat_hist <= '0;
      plat_pend <= '0;
    end else begin
      msi_q     <= msi_i;
      mti_q     <= mti_i;
      mei_q     <= mei_i;
      plat_sync <= {plat_sync[SYNC_STAGES-2:0], plat_irq_i};
      plat_hist <= plat_sync[SYNC_STAGES-1];
      plat_pend <= plat_pend_nxt;
    end
  end

  assign plat_rise = plat_sync[SYNC_STAGES-1] & ~plat_hist;

  // A fresh edge overrides a clear landing in the same cycle.
  always_comb begin
    plat_clr = '0;
    for (int i = 0; i < NUM_PLAT_IRQ; i++) begin
      plat_clr[i] = (pend_clr_i && (pend_clr_code_i == 5'(16 + i))) ||
                    (ack_take && (trap_code_o == 5'(16 + i)));
    end
    plat_pend_nxt = (plat_pend & ~plat_clr) | plat_rise;
  end

  always_comb begin
    mip      = '0;
    mip.msi  = msi_q;
    mip.mti  = mti_q;
    mip.mei  = mei_q;
    mip.plat = plat_pend;
  end

  assign mip_o    = mip;
  assign eligible = mip & mie_i & {32{mstatus_mie_i}};
  assign any_elig = |eligible;

  // Descending scan so the lowest platform code is left as the winner.
  always_comb begin
    win_code = '0;
    if (eligible[11])      win_code = 5'd11;
    else if (eligible[3])  win_code = 5'd3;
    else if (eligible[7])  win_code = 5'd7;
    else begin
      for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
        if (eligible[16 + i]) win_code = 5'(16 + i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      trap_req_o  <= 1'b0;
      trap_code_o <= '0;
    end else begin
      state_q     <= state_nxt;
      trap_req_o  <= req_nxt;
      trap_code_o <= code_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    req_nxt   = trap_req_o;
    code_nxt  = trap_code_o;
    ack_take  = 1'b0;
    case (state_q)
      IDLE: begin
        req_nxt  = 1'b0;
        code_nxt = '0;
        if (any_elig) begin
          state_nxt = REQ;
          req_nxt   = 1'b1;
          code_nxt  = win_code;
        end
      end
      REQ: begin
        // Ack takes precedence over a simultaneous loss of eligibility.
        if (trap_ack_i) begin
          ack_take  = 1'b1;
          state_nxt = HOLD;
          req_nxt   = 1'b0;
          code_nxt  = '0;
        end else if (!eligible[trap_code_o]) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
          code_nxt  = '0;
        end
      end
      HOLD: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
        code_nxt  = '0;
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
        code_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: hand-computed expectations, sampled 1 time unit after each rising edge.
module tb_irq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        msi_i, mti_i, mei_i;
  logic [9:0]  plat_irq_i;
  logic [31:0] mie_i;
  logic        mstatus_mie_i;
  logic        pend_clr_i;
  logic [4:0]  pend_clr_code_i;
  logic [31:0] mip_o;
  logic        trap_req_o;
  logic [4:0]  trap_code_o;
  logic        trap_ack_i;

  int tests_run    = 0;
  int tests_failed = 0;

  irq_ctrl #(.NUM_PLAT_IRQ(10), .SYNC_STAGES(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .msi_i           (msi_i),
    .mti_i           (mti_i),
    .mei_i           (mei_i),
    .plat_irq_i      (plat_irq_i),
    .mie_i           (mie_i),
    .mstatus_mie_i   (mstatus_mie_i),
    .pend_clr_i      (pend_clr_i),
    .pend_clr_code_i (pend_clr_code_i),
    .mip_o           (mip_o),
    .trap_req_o      (trap_req_o),
    .trap_code_o     (trap_code_o),
    .trap_ack_i      (trap_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_req(input string tag, input logic req, input logic [4:0] code);
    check({tag, "_req"}, 32'(trap_req_o), 32'(req));
    check({tag, "_code"}, 32'(trap_code_o), 32'(code));
  endtask

  initial begin
    rst_n = 1'b0;
    msi_i = 1'b0; mti_i = 1'b0; mei_i = 1'b0;
    plat_irq_i = '0; mie_i = '0; mstatus_mie_i = 1'b0;
    pend_clr_i = 1'b0; pend_clr_code_i = '0; trap_ack_i = 1'b0;

    // 1: reset held while every input toggles
    for (int c = 0; c < 4; c++) begin
      msi_i = ~msi_i; mti_i = ~mti_i; mei_i = ~mei_i;
      plat_irq_i = ~plat_irq_i; mie_i = ~mie_i; mstatus_mie_i = ~mstatus_mie_i;
      trap_ack_i = ~trap_ack_i; pend_clr_i = ~pend_clr_i;
      tick();
      check("rst_mip", mip_o, 32'h0);
      check_req("rst", 1'b0, 5'd0);
    end
    msi_i = 1'b0; mti_i = 1'b0; mei_i = 1'b0; plat_irq_i = '0; mie_i = '0;
    mstatus_mie_i = 1'b0; trap_ack_i = 1'b0; pend_clr_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();

    // 2: plat[2] edge -> mip[18] at +3, req code 18 at +4, ack clears
    mie_i = 32'h0004_0000; mstatus_mie_i = 1'b1;
    plat_irq_i[2] = 1'b1;
    tick(); tick();
    check("p2_mip_early", mip_o, 32'h0);
    tick();
    check("p2_mip", mip_o, 32'h0004_0000);
    check_req("p2_noreq", 1'b0, 5'd0);
    tick();
    check_req("p2", 1'b1, 5'd18);
    tick();
    check_req("p2_held", 1'b1, 5'd18);
    trap_ack_i = 1'b1;
    tick();
    trap_ack_i = 1'b0;
    check_req("p2_ack", 1'b0, 5'd0);
    check("p2_mip_clr", mip_o, 32'h0);
    tick();
    check_req("p2_idle", 1'b0, 5'd0);
    plat_irq_i = '0;
    tick(); tick();

    // 3: priority MEI > MTI > plat 20, frozen code while newer source arrives
    mie_i = 32'h03FF_0888;
    mei_i = 1'b1; mti_i = 1'b1; plat_irq_i[4] = 1'b1;
    tick(); tick();
    check_req("pr_mei", 1'b1, 5'd11);
    tick();
    check("pr_mip", mip_o, 32'h0010_0880);
    check_req("pr_frozen", 1'b1, 5'd11);
    trap_ack_i = 1'b1; mei_i = 1'b0;
    tick();
    trap_ack_i = 1'b0;
    check_req("pr_hold", 1'b0, 5'd0);
    tick();
    check_req("pr_idle", 1'b0, 5'd0);
    tick();
    check_req("pr_mti", 1'b1, 5'd7);
    trap_ack_i = 1'b1; mti_i = 1'b0;
    tick();
    trap_ack_i = 1'b0;
    tick(); tick();
    check_req("pr_plat", 1'b1, 5'd20);
    trap_ack_i = 1'b1;
    tick();
    trap_ack_i = 1'b0;
    check_req("pr_done", 1'b0, 5'd0);
    check("pr_mip_clr", mip_o, 32'h0);
    plat_irq_i = '0;
    tick(); tick();

    // 4: withdraw when mie[7] drops, then FSM back in IDLE
    mie_i = 32'h0000_0080; mti_i = 1'b1;
    tick(); tick();
    check_req("wd_req", 1'b1, 5'd7);
    mie_i = 32'h0;
    tick();
    check_req("wd_gone", 1'b0, 5'd0);
    mie_i = 32'h0000_0080;
    tick();
    check_req("wd_reidle", 1'b1, 5'd7);
    trap_ack_i = 1'b1; mti_i = 1'b0;
    tick();
    trap_ack_i = 1'b0;
    check_req("wd_ack", 1'b0, 5'd0);
    mie_i = 32'h0;
    tick(); tick();

    // 5: edge beats simultaneous software clear; wrong code ignored; clear alone works
    plat_irq_i[5] = 1'b1;
    tick(); tick();
    pend_clr_i = 1'b1; pend_clr_code_i = 5'd21;
    tick();
    check("clr_race", mip_o, 32'h0020_0000);
    pend_clr_code_i = 5'd22;
    tick();
    check("clr_other", mip_o, 32'h0020_0000);
    pend_clr_code_i = 5'd26;
    tick();
    check("clr_oob", mip_o, 32'h0020_0000);
    pend_clr_code_i = 5'd21;
    tick();
    pend_clr_i = 1'b0;
    check("clr_alone", mip_o, 32'h0);
    check_req("clr_noreq", 1'b0, 5'd0);
    plat_irq_i = '0;
    tick(); tick();

    // 6: async reset mid-REQ discards the pending event
    mie_i = 32'h0001_0000;
    plat_irq_i[0] = 1'b1;
    tick(); tick(); tick(); tick();
    check_req("ar_req", 1'b1, 5'd16);
    #2;
    rst_n = 1'b0;
    plat_irq_i[0] = 1'b0;
    #1;
    check_req("ar_async", 1'b0, 5'd0);
    check("ar_mip", mip_o, 32'h0);
    rst_n = 1'b1;
    tick();
    check("ar_post_mip", mip_o, 32'h0);
    tick(); tick(); tick();
    check("ar_late_mip", mip_o, 32'h0);
    check_req("ar_late", 1'b0, 5'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
